// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate bounds, synchronous load,
// terminal-count prediction and sticky overflow/underflow flags.
module updown_counter_param #(
  parameter int     WIDTH     = 3,
  parameter longint MODULUS   = 8,
  parameter bit     SATURATE  = 1'b0,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             bound,
  output logic             ovf,
  output logic             unf
);

  // MODULUS may equal 2^WIDTH, so it is held one bit wider than the count.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
      MODULUS > (longint'(1) << WIDTH) ||
      RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_error
    $error("updown_counter_param: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;
  logic             hit_up;
  logic             hit_dn;

  assign load_clamped = ({1'b0, load_val} >= MOD_W) ? MAX_VAL : load_val;
  assign hit_up       = tc & updown;
  assign hit_dn       = tc & ~updown;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves a variable unassigned and infers a latch.
  always_comb begin
    tc         = 1'b0;
    next_count = counter;
    if (en && !load) begin
      tc = updown ? (counter == MAX_VAL) : (counter == '0);
    end
    if (load) begin
      next_count = load_clamped;
    end else if (en) begin
      if (tc) begin
        if (!SATURATE) next_count = updown ? '0 : MAX_VAL;
      end else begin
        next_count = updown ? counter + 1'b1 : counter - 1'b1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= RST_V;
      bound   <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      counter <= next_count;
      bound   <= tc;
      // A new event beats a simultaneous clear.
      ovf     <= hit_up | (ovf & ~clr_flags);
      unf     <= hit_dn | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: default wrap instance plus a
// MODULUS=6 saturating instance, checked against hand-computed values.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       reset, en, updown, load, clr_flags;
  logic [2:0] load_val;
  logic [2:0] counter;
  logic       tc, bound, ovf, unf;

  logic       s_reset, s_en, s_updown, s_load, s_clr_flags;
  logic [2:0] s_load_val;
  logic [2:0] s_counter;
  logic       s_tc, s_bound, s_ovf, s_unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter_param dut (
    .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .counter(counter),
    .tc(tc), .bound(bound), .ovf(ovf), .unf(unf)
  );

  updown_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1), .RESET_VAL(0)) dut_sat (
    .clk(clk), .reset(s_reset), .en(s_en), .updown(s_updown), .load(s_load),
    .load_val(s_load_val), .clr_flags(s_clr_flags), .counter(s_counter),
    .tc(s_tc), .bound(s_bound), .ovf(s_ovf), .unf(s_unf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cur;
    bit  hit;
    bit  ovf_exp;

    reset = 1'b0; en = 1'b0; updown = 1'b0; load = 1'b0; clr_flags = 1'b0;
    load_val = '0;
    s_reset = 1'b0; s_en = 1'b0; s_updown = 1'b0; s_load = 1'b0;
    s_clr_flags = 1'b0; s_load_val = '0;
    #3;
    check("rst_counter", counter, 0);
    check("rst_bound", bound, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    @(negedge clk);
    reset = 1'b1; s_reset = 1'b1;

    // Count up through the 7->0 wrap.
    en = 1'b1; updown = 1'b1;
    cur = 0; ovf_exp = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      check($sformatf("up_tc_%0d", i), tc, (cur == 7));
      step();
      hit = (cur == 7);
      cur = (cur + 1) % 8;
      ovf_exp = ovf_exp | hit;
      check($sformatf("up_cnt_%0d", i), counter, cur);
      check($sformatf("up_bound_%0d", i), bound, hit);
      check($sformatf("up_ovf_%0d", i), ovf, ovf_exp);
    end
    en = 1'b0; clr_flags = 1'b1;
    step();
    check("clr_ovf", ovf, 0);
    check("clr_hold_cnt", counter, 1);
    check("clr_bound", bound, 0);
    clr_flags = 1'b0;

    // Count down through the 0->7 wrap.
    load = 1'b1; load_val = 3'd0;
    step();
    load = 1'b0;
    check("ld0_cnt", counter, 0);
    en = 1'b1; updown = 1'b0;
    #1;
    check("dn_tc", tc, 1);
    step();
    check("dn_cnt_a", counter, 7);
    check("dn_bound_a", bound, 1);
    check("dn_unf_a", unf, 1);
    step();
    check("dn_cnt_b", counter, 6);
    check("dn_bound_b", bound, 0);
    check("dn_unf_b", unf, 1);
    en = 1'b0; clr_flags = 1'b1;
    step();
    check("clr_unf", unf, 0);
    clr_flags = 1'b0;

    // Load beats count on the same edge, then hold.
    load = 1'b1; load_val = 3'd3;
    step();
    check("ld3_cnt", counter, 3);
    load_val = 3'd6; en = 1'b1; updown = 1'b1;
    #1;
    check("ld_tc_masked", tc, 0);
    step();
    check("ld_over_en", counter, 6);
    check("ld_bound", bound, 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold_tc_%0d", i), tc, 0);
      step();
      check($sformatf("hold_cnt_%0d", i), counter, 6);
    end

    // Load at the top bound sets no flags; overflow with clr_flags keeps ovf.
    load = 1'b1; load_val = 3'd7; en = 1'b1; updown = 1'b1;
    step();
    check("ld7_cnt", counter, 7);
    check("ld7_bound", bound, 0);
    check("ld7_ovf", ovf, 0);
    load = 1'b0;
    step();
    check("ovf_set", ovf, 1);
    load = 1'b1; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; clr_flags = 1'b1;
    step();
    check("set_wins_cnt", counter, 0);
    check("set_wins_ovf", ovf, 1);
    check("set_wins_bound", bound, 1);
    en = 1'b0; load = 1'b1; load_val = 3'd2;
    step();
    check("clr_load_ovf", ovf, 0);
    check("clr_load_cnt", counter, 2);
    load = 1'b0; clr_flags = 1'b0;

    // Asynchronous reset between edges.
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0; en = 1'b1; updown = 1'b1;
    step();
    check("pre_rst_ovf", ovf, 1);
    check("pre_rst_bound", bound, 1);
    step();
    check("pre_rst_cnt", counter, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_cnt", counter, 0);
    check("arst_bound", bound, 0);
    check("arst_ovf", ovf, 0);
    step();
    check("arst_held", counter, 0);
    reset = 1'b1;
    step();
    check("rel_cnt", counter, 1);
    en = 1'b0;

    // Saturating MODULUS=6 instance.
    s_load = 1'b1; s_load_val = 3'd7;
    step();
    check("sat_clamp", s_counter, 5);
    check("sat_ld_bound", s_bound, 0);
    check("sat_ld_ovf", s_ovf, 0);
    check("sat_ld_unf", s_unf, 0);
    s_load = 1'b0; s_en = 1'b1; s_updown = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("sat_tc_%0d", i), s_tc, 1);
      step();
      check($sformatf("sat_cnt_%0d", i), s_counter, 5);
      check($sformatf("sat_bound_%0d", i), s_bound, 1);
      check($sformatf("sat_ovf_%0d", i), s_ovf, 1);
    end
    s_updown = 1'b0;
    step();
    check("sat_dn_cnt", s_counter, 4);
    check("sat_dn_bound", s_bound, 0);
    s_load = 1'b1; s_load_val = 3'd0;
    step();
    s_load = 1'b0;
    step();
    check("sat_floor_cnt", s_counter, 0);
    check("sat_floor_bound", s_bound, 1);
    check("sat_floor_unf", s_unf, 1);
    s_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter; next generation of the team's 3-bit up/down counter.
- Adds:
  - programmable width and modulus;
  - wrap or saturate mode;
  - count enable and synchronous load;
  - terminal-count indication and sticky overflow/underflow flags.
- Used as a general event/position counter in datapath and control blocks. Default parameters match the 3-bit wrap counter.

Parameters:
- WIDTH, 3: counter width in bits; range 1..32.
- MODULUS, 8: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0: 0 = wrap at bounds, 1 = hold at bounds.
- RESET_VAL, 0: counter value on reset; must be < MODULUS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- en  input  1  count enable.
- updown  input  1  1 = count up, 0 = count down; sampled when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- clr_flags  input  1  synchronous clear of ovf/unf.
- counter  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- bound  output  1  registered one-cycle pulse when a bound is hit.
- ovf  output  1  sticky overflow flag (registered).
- unf  output  1  sticky underflow flag (registered).

Behaviour:
- Reset:
  - reset=0 immediately forces counter=RESET_VAL, bound=0, ovf=0, unf=0, regardless of clk.
  - On release, counting resumes at the first rising edge with reset=1.
  - Reset mid-count discards all state.
- Per-edge priority: reset > load > en > hold.
- Load:
  - load=1 sets counter=load_val next edge, overriding en/updown.
  - load_val >= MODULUS is clamped to MODULUS-1.
  - Load never sets bound/ovf/unf.
- Count up (en=1, load=0, updown=1):
  - counter < MODULUS-1: counter+1.
  - counter = MODULUS-1:
    - SATURATE=0: counter=0.
    - SATURATE=1: counter holds.
    - Both modes: bound=1 for one cycle, ovf set.
- Count down (en=1, load=0, updown=0):
  - counter > 0: counter-1.
  - counter = 0:
    - SATURATE=0: counter=MODULUS-1.
    - SATURATE=1: counter holds.
    - Both modes: bound=1 for one cycle, unf set.
- Hold: en=0 and load=0 keep counter unchanged; bound=0.
- Arithmetic:
  - All compares and increments are WIDTH-bit unsigned.
  - When MODULUS = 2^WIDTH, wrap equals natural WIDTH-bit rollover.
  - No intermediate value >= MODULUS is ever visible on counter.
- tc = en & ~load & (updown ? counter==MODULUS-1 : counter==0). tc predicts that the next edge hits a bound; bound follows tc by exactly one cycle.
- bound is registered and goes high the cycle after the boundary edge. Example: counter 7->0 on edge N gives bound=1 during cycle N..N+1. It is deasserted on any edge without a boundary event.
- Flags:
  - ovf/unf stay set until clr_flags=1 or reset.
  - clr_flags and a new event in the same cycle: set wins.
  - clr_flags and load in the same cycle: flags clear.
- Latency: counter, bound and flags all update one edge after the qualifying inputs. tc is zero-latency combinational.
- Elaboration: parameter violations (MODULUS > 2^WIDTH, MODULUS < 2, RESET_VAL >= MODULUS) are elaboration errors, not runtime behaviour.

Test Plan:
- Defaults; reset=0 then 1; en=1, updown=1 for 9 edges:
  - counter 0,1,...,7,0,1.
  - tc=1 while counter=7.
  - bound=1 one cycle after 7->0.
  - ovf=1 afterwards.
- Defaults, counter=0, updown=0, en=1 for 2 edges:
  - counter 7 then 6.
  - unf=1, bound pulse after 0->7.
  - clr_flags=1 one edge later gives unf=0.
- MODULUS=6, SATURATE=1; load_val=7 with load=1:
  - counter=5 (clamped), no flags.
  - Then up for 3 edges: counter stays 5, bound=1 on each edge, ovf=1.
- Defaults, counter=3; load=1, load_val=6, en=1, updown=1 on the same edge:
  - counter=6, not 4.
  - Then en=0 for 4 edges: counter holds 6, tc=0.
- Defaults, counter=7, updown=1, en=1; clr_flags=1 on the overflow edge with ovf previously set: ovf remains 1.
- Defaults, counting up; assert reset=0 mid-cycle between edges:
  - counter=0, flags=0 immediately without a clock edge.
  - Release: next edge counter=1.
